ysyx_24090012_mem_arb: RTL

YSYX_24090012_MEM_ARB -- requirements
Module: ysyx_24090012_mem_arb

---
 rtl/ysyx_24090012_mem_arb.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24090012_mem_arb.sv
// ysyx_24090012_mem_arb
// Two-master (m0 = IFU, m1 = LSU) to one-slave memory arbiter with round-robin
// tie breaking and a single transaction in flight.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   m<i>_req_*            master request channel (valid/ready, addr, wen, wdata, wstrb)
//   m<i>_rsp_*            master response channel (valid/ready, rdata, err)
//   m<i>_grant_cnt        completed transactions per master (wraps)
//   s_req_*               slave request channel driven from the latched request
//   s_rsp_*               slave response channel
//   state_out             current FSM state for debug
module ysyx_24090012_mem_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_req_valid,
  input  logic                  m1_req_valid,
  output logic                  m0_req_ready,
  output logic                  m1_req_ready,
  input  logic [ADDR_W-1:0]     m0_req_addr,
  input  logic [ADDR_W-1:0]     m1_req_addr,
  input  logic                  m0_req_wen,
  input  logic                  m1_req_wen,
  input  logic [DATA_W-1:0]     m0_req_wdata,
  input  logic [DATA_W-1:0]     m1_req_wdata,
  input  logic [DATA_W/8-1:0]   m0_req_wstrb,
  input  logic [DATA_W/8-1:0]   m1_req_wstrb,
  output logic                  m0_rsp_valid,
  output logic                  m1_rsp_valid,
  input  logic                  m0_rsp_ready,
  input  logic                  m1_rsp_ready,
  output logic [DATA_W-1:0]     m0_rsp_rdata,
  output logic [DATA_W-1:0]     m1_rsp_rdata,
  output logic                  m0_rsp_err,
  output logic                  m1_rsp_err,
  output logic [CNT_W-1:0]      m0_grant_cnt,
  output logic [CNT_W-1:0]      m1_grant_cnt,
  output logic                  s_req_valid,
  input  logic                  s_req_ready,
  output logic [ADDR_W-1:0]     s_req_addr,
  output logic                  s_req_wen,
  output logic [DATA_W-1:0]     s_req_wdata,
  output logic [DATA_W/8-1:0]   s_req_wstrb,
  input  logic                  s_rsp_valid,
  output logic                  s_rsp_ready,
  input  logic [DATA_W-1:0]     s_rsp_rdata,
  input  logic                  s_rsp_err,
  output logic [1:0]            state_out
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  state_t            state;
  logic              last_grant;
  logic              owner;
  req_t              req_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt1_q;

  logic              winner_c;
  logic              idle_c;
  logic              accept_c;
  logic              owner_rsp_ready_c;
  req_t              req_in_c;

  // Round-robin: a lone requester wins, a tie goes to the master not granted last.
  always_comb begin
    winner_c = 1'b0;
    if (m0_req_valid && m1_req_valid) begin
      winner_c = ~last_grant;
    end else if (m1_req_valid) begin
      winner_c = 1'b1;
    end
  end

  // Readies are held low while reset is asserted, not just after the reset edge.
  assign idle_c       = reset && (state == IDLE);
  assign m0_req_ready = idle_c && m0_req_valid && !winner_c;
  assign m1_req_ready = idle_c && m1_req_valid &&  winner_c;
  assign accept_c     = m0_req_ready || m1_req_ready;

  // Request fields of the current winner.
  always_comb begin
    req_in_c = '0;
    if (winner_c) begin
      req_in_c.addr  = m1_req_addr;
      req_in_c.wen   = m1_req_wen;
      req_in_c.wdata = m1_req_wdata;
      req_in_c.wstrb = m1_req_wstrb;
    end else begin
      req_in_c.addr  = m0_req_addr;
      req_in_c.wen   = m0_req_wen;
      req_in_c.wdata = m0_req_wdata;
      req_in_c.wstrb = m0_req_wstrb;
    end
  end

  assign owner_rsp_ready_c = owner ? m1_rsp_ready : m0_rsp_ready;

  // Transaction FSM; all request/response payloads are latched copies.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      req_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            req_q      <= req_in_c;
            owner      <= winner_c;
            last_grant <= winner_c;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (s_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (s_rsp_valid) begin
            rdata_q <= s_rsp_rdata;
            err_q   <= s_rsp_err;
            state   <= RESP;
          end
        end
        RESP: begin
          if (owner_rsp_ready_c) begin
            if (owner) begin
              cnt1_q <= cnt1_q + CNT_W'(1);
            end else begin
              cnt0_q <= cnt0_q + CNT_W'(1);
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave side decodes straight from the state register.
  assign s_req_valid = reset && (state == ISSUE);
  assign s_rsp_ready = reset && (state == WAIT);
  assign s_req_addr  = req_q.addr;
  assign s_req_wen   = req_q.wen;
  assign s_req_wdata = req_q.wdata;
  assign s_req_wstrb = req_q.wstrb;

  // Only the owning master sees the response; the other side stays quiet.
  assign m0_rsp_valid = reset && (state == RESP) && !owner;
  assign m1_rsp_valid = reset && (state == RESP) &&  owner;
  assign m0_rsp_rdata = owner ? '0 : rdata_q;
  assign m1_rsp_rdata = owner ? rdata_q : '0;
  assign m0_rsp_err   = !owner && err_q;
  assign m1_rsp_err   =  owner && err_q;

  assign m0_grant_cnt = cnt0_q;
  assign m1_grant_cnt = cnt1_q;
  assign state_out    = state;

endmodule
